// File: rtl/mod_step_arbiter_if.sv
// Request/grant bundle between the requesters and the step arbiter.
// The arbiter owns every signal except REQ.
interface mod_step_arbiter_if #(
    parameter int NREQ = 4,
    parameter int CW   = 3
);
    logic [NREQ-1:0] REQ;
    logic [NREQ-1:0] GNT;
    logic            STEP;
    logic [CW-1:0]   PHASE;
    logic            WRAP;
    logic            BUSY;
    logic            Y;

    modport master (output REQ, input GNT, STEP, PHASE, WRAP, BUSY, Y);
    modport slave  (input REQ, output GNT, STEP, PHASE, WRAP, BUSY, Y);
endinterface

// File: rtl/mod_step_arbiter.sv
// Round-robin step arbiter sharing one modulo-MOD phase counter; REQ seen in IDLE -> one-cycle grant next cycle.
// No backpressure: REQ is only sampled in IDLE, and each grant is followed by GAP dead cycles.
module mod_step_arbiter #(
    parameter int NREQ = 4,
    parameter int MOD  = 5,
    parameter int CW   = 3,
    parameter int GAP  = 2
) (
    input  logic                   CLK,
    input  logic                   R,
    mod_step_arbiter_if.slave      bus
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] PHASE_MAX = CW'(MOD - 1);
    localparam logic [7:0] GAP_M1 = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t          stateQ, stateN;
    logic [NREQ-1:0] gntQ, gntN;
    logic            wrapQ, wrapN;
    logic [CW-1:0]   phaseQ, phaseN;
    logic [LW-1:0]   lastQ, lastN;
    logic [7:0]      cntQ, cntN;
    logic [LW-1:0]   winner;
    logic            found;

    // Search starts just past the last winner so a persistent requester goes to the back of the line.
    always_comb begin
        winner = lastQ;
        found  = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            if (!found && bus.REQ[LW'((int'(lastQ) + off) % NREQ)]) begin
                winner = LW'((int'(lastQ) + off) % NREQ);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        stateN = stateQ;
        gntN   = '0;
        wrapN  = 1'b0;
        phaseN = phaseQ;
        lastN  = lastQ;
        cntN   = cntQ;
        case (stateQ)
            IDLE: begin
                if (found) begin
                    stateN = GRANT;
                    gntN   = NREQ'(1) << winner;
                    lastN  = winner;
                    wrapN  = (phaseQ == PHASE_MAX);
                    phaseN = (phaseQ == PHASE_MAX) ? '0 : phaseQ + CW'(1);
                end
            end
            GRANT: begin
                if (GAP == 0) begin
                    stateN = IDLE;
                end else begin
                    stateN = HOLD;
                    cntN   = GAP_M1;
                end
            end
            HOLD: begin
                if (cntQ == 8'd0) stateN = IDLE;
                else              cntN   = cntQ - 8'd1;
            end
            default: stateN = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!R) begin
            stateQ <= IDLE;
            gntQ   <= '0;
            wrapQ  <= 1'b0;
            phaseQ <= '0;
            lastQ  <= LW'(NREQ - 1);
            cntQ   <= 8'd0;
        end else begin
            stateQ <= stateN;
            gntQ   <= gntN;
            wrapQ  <= wrapN;
            phaseQ <= phaseN;
            lastQ  <= lastN;
            cntQ   <= cntN;
        end
    end

    assign bus.GNT   = gntQ;
    assign bus.STEP  = |gntQ;
    assign bus.WRAP  = wrapQ;
    assign bus.PHASE = phaseQ;
    assign bus.BUSY  = (stateQ != IDLE);
    assign bus.Y     = (phaseQ == '0);
endmodule

// File: tb/tb_mod_step_arbiter.sv
// Directed bench: row table for the GAP=2/MOD=5 arbiter, hand sequence for a GAP=0/MOD=1 arbiter.
module tb_mod_step_arbiter;
    logic CLK = 1'b0;
    logic R   = 1'b0;
    always #5 CLK = ~CLK;

    mod_step_arbiter_if #(.NREQ(4), .CW(3)) busA ();
    mod_step_arbiter_if #(.NREQ(4), .CW(1)) busB ();

    mod_step_arbiter #(.NREQ(4), .MOD(5), .CW(3), .GAP(2)) dutA (
        .CLK(CLK), .R(R), .bus(busA.slave)
    );
    mod_step_arbiter #(.NREQ(4), .MOD(1), .CW(1), .GAP(0)) dutB (
        .CLK(CLK), .R(R), .bus(busB.slave)
    );

    typedef struct {
        logic       r;
        logic [3:0] req;
        logic [3:0] gnt;
        logic       step;
        logic [2:0] phase;
        logic       wrap;
        logic       busy;
        logic       y;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;

    task automatic add(input logic r, input logic [3:0] req, input logic [3:0] gnt,
                       input logic step, input logic [2:0] phase, input logic wrap,
                       input logic busy, input logic y);
        vec_t v;
        v = '{r, req, gnt, step, phase, wrap, busy, y};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, exp);
        end
    endtask

    // Grant row followed by two HOLD rows and the row where HOLD expires back to IDLE.
    task automatic addGrant(input logic [3:0] req, input logic [3:0] gnt, input logic [2:0] ph, input logic wrap);
        add(1, req, gnt, 1, ph, wrap, 1, ph == 0);
        add(1, req, 4'b0000, 0, ph, 0, 1, ph == 0);
        add(1, req, 4'b0000, 0, ph, 0, 1, ph == 0);
        add(1, req, 4'b0000, 0, ph, 0, 0, ph == 0);
    endtask

    initial begin
        logic [3:0] expG;
        int steps;
        busA.REQ = 4'b0000;
        busB.REQ = 4'b0000;

        // reset held with all requests asserted
        add(0, 4'b1111, 4'b0000, 0, 0, 0, 0, 1);
        add(0, 4'b1111, 4'b0000, 0, 0, 0, 0, 1);
        // single request; REQ flooded during HOLD must be ignored
        add(1, 4'b0100, 4'b0100, 1, 1, 0, 1, 0);
        add(1, 4'b1111, 4'b0000, 0, 1, 0, 1, 0);
        add(1, 4'b1111, 4'b0000, 0, 1, 0, 1, 0);
        add(1, 4'b1111, 4'b0000, 0, 1, 0, 0, 0);
        add(1, 4'b0000, 4'b0000, 0, 1, 0, 0, 0);
        // rotation from reset with phase walking 1..4,0
        add(0, 4'b1111, 4'b0000, 0, 0, 0, 0, 1);
        addGrant(4'b1111, 4'b0001, 1, 0);
        addGrant(4'b1111, 4'b0010, 2, 0);
        addGrant(4'b1111, 4'b0100, 3, 0);
        addGrant(4'b1111, 4'b1000, 4, 0);
        add(1, 4'b1111, 4'b0001, 1, 0, 1, 1, 1);
        add(1, 4'b0000, 4'b0000, 0, 0, 0, 1, 1);
        // reset mid-HOLD after a grant to requester 2
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
        add(1, 4'b0100, 4'b0100, 1, 1, 0, 1, 0);
        add(1, 4'b0000, 4'b0000, 0, 1, 0, 1, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
        add(1, 4'b1111, 4'b0001, 1, 1, 0, 1, 0);

        foreach (vecs[i]) begin
            R = vecs[i].r;
            busA.REQ = vecs[i].req;
            @(posedge CLK);
            #1;
            check("gnt",   i, 32'(busA.GNT),   32'(vecs[i].gnt));
            check("step",  i, 32'(busA.STEP),  32'(vecs[i].step));
            check("phase", i, 32'(busA.PHASE), 32'(vecs[i].phase));
            check("wrap",  i, 32'(busA.WRAP),  32'(vecs[i].wrap));
            check("busy",  i, 32'(busA.BUSY),  32'(vecs[i].busy));
            check("y",     i, 32'(busA.Y),     32'(vecs[i].y));
        end
        check("b_idle_gnt", 0, 32'(busB.GNT), 32'(0));

        // GAP=0, MOD=1: alternating grants every other cycle, WRAP on each one
        R = 1'b0;
        busA.REQ = 4'b0000;
        busB.REQ = 4'b0011;
        @(posedge CLK);
        #1;
        R = 1'b1;
        steps = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            expG = (i % 2 == 1) ? 4'b0000 : (((i / 2) % 2 == 1) ? 4'b0010 : 4'b0001);
            if (busB.STEP === 1'b1) steps++;
            check("b_gnt",   i, 32'(busB.GNT),   32'(expG));
            check("b_wrap",  i, 32'(busB.WRAP),  32'(expG != 0));
            check("b_phase", i, 32'(busB.PHASE), 32'(0));
            check("b_y",     i, 32'(busB.Y),     32'(1));
            check("b_busy",  i, 32'(busB.BUSY),  32'(expG != 0));
        end
        check("b_step_duty", 0, 32'(steps), 32'(4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
